// File: rtl/poly_nco.sv
// Polyphonic numerically-controlled oscillator: NUM_VOICES phase accumulators
// are stepped one per clock once per sample period and mixed into one sample.
module poly_nco #(
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 16,
  parameter int SAMPLE_DIV = 2268
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_addr,
  input  logic [ACC_W-1:0]              cfg_tuning,
  input  logic [1:0]                    cfg_mode,
  input  logic                          cfg_gate,
  output logic [OUT_W-1:0]              sample_out,
  output logic                          sample_valid,
  output logic [NUM_VOICES-1:0]         square_out,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int SUM_W = OUT_W + IDX_W;
  localparam int DIV_W = $clog2(SAMPLE_DIV);

  if (NUM_VOICES < 2 || NUM_VOICES > 16 || (NUM_VOICES & (NUM_VOICES - 1)) != 0) begin : g_bad_voices
    $error("poly_nco: NUM_VOICES must be a power of two in 2..16");
  end
  if (OUT_W > ACC_W) begin : g_bad_out_w
    $error("poly_nco: OUT_W must not exceed ACC_W");
  end
  if (SAMPLE_DIV < NUM_VOICES + 2) begin : g_bad_div
    $error("poly_nco: SAMPLE_DIV must be at least NUM_VOICES+2");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_SQUARE = 2'b00,
    MODE_SAW    = 2'b01,
    MODE_TRI    = 2'b10,
    MODE_SILENT = 2'b11
  } mode_e;

  typedef struct packed {
    logic [ACC_W-1:0] tuning;
    mode_e            mode;
    logic             gate;
  } voice_cfg_t;

  voice_cfg_t       cfg_q [NUM_VOICES];
  logic [ACC_W-1:0] acc_q [NUM_VOICES];

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [IDX_W-1:0] idx_q;
  logic [SUM_W-1:0] sum_q;
  logic             tick;
  logic             last_voice;

  voice_cfg_t       cur_cfg;
  logic [ACC_W-1:0] acc_next;
  logic [OUT_W-1:0] phase;
  logic [OUT_W-1:0] tri_u;
  logic [OUT_W-1:0] wave;
  logic [OUT_W-1:0] contrib;
  logic [SUM_W-1:0] sum_next;

  // Voice configuration. A write landing in a voice's RUN slot is seen by the
  // datapath only from the following sample, because the slot reads cfg_q.
  // NOTE: the config and accumulator arrays are small flop banks, not RAM, so
  // they take the asynchronous reset like every other register here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        cfg_q[v] <= '{tuning: '0, mode: MODE_SQUARE, gate: 1'b0};
      end
    end else if (cfg_we) begin
      cfg_q[cfg_addr] <= '{tuning: cfg_tuning, mode: mode_e'(cfg_mode), gate: cfg_gate};
    end
  end

  // Free-running sample-rate divider.
  assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // Per-slot voice datapath: next phase, waveform shaping, mixing.
  always_comb begin
    // NOTE: defaults first so no path through this block can infer a latch.
    cur_cfg  = cfg_q[idx_q];
    acc_next = cur_cfg.gate ? (acc_q[idx_q] + cur_cfg.tuning) : '0;
    phase    = acc_next[ACC_W-1 -: OUT_W];
    tri_u    = {phase[OUT_W-2:0], 1'b0};
    wave     = '0;
    if (phase[OUT_W-1]) begin
      tri_u = ~tri_u;
    end
    case (cur_cfg.mode)
      MODE_SQUARE: wave = phase[OUT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                         : {1'b0, {(OUT_W-1){1'b1}}};
      MODE_SAW:    wave = {~phase[OUT_W-1], phase[OUT_W-2:0]};
      MODE_TRI:    wave = {~tri_u[OUT_W-1], tri_u[OUT_W-2:0]};
      default:     wave = '0;
    endcase
    contrib  = cur_cfg.gate ? wave : '0;
    sum_next = sum_q + {{IDX_W{contrib[OUT_W-1]}}, contrib};
  end

  assign last_voice = (idx_q == IDX_W'(NUM_VOICES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_RUN;
      ST_RUN:  if (last_voice) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer datapath. The output register loads on the final RUN edge so
  // that sample_out and sample_valid are both presented during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      sum_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        acc_q[v] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            idx_q <= '0;
            sum_q <= '0;
          end
        end
        ST_RUN: begin
          acc_q[idx_q] <= acc_next;
          sum_q        <= sum_next;
          idx_q        <= idx_q + IDX_W'(1);
          if (last_voice) begin
            // Top OUT_W bits of the sum equal the arithmetic shift by IDX_W.
            sample_out   <= sum_next[SUM_W-1 -: OUT_W];
            sample_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      square_out[v] = acc_q[v][ACC_W-1];
    end
  end

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_poly_nco.sv
// Directed self-checking bench for poly_nco with a short sample period (8 clocks).
module tb_poly_nco;

  localparam int NV = 4;
  localparam int AW = 32;
  localparam int OW = 16;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [AW-1:0] cfg_tuning = '0;
  logic [1:0]    cfg_mode = '0;
  logic          cfg_gate = 1'b0;
  logic [OW-1:0] sample_out;
  logic          sample_valid;
  logic [NV-1:0] square_out;
  logic          busy;

  int errors = 0;
  int checks = 0;

  poly_nco #(
    .NUM_VOICES(NV),
    .ACC_W     (AW),
    .OUT_W     (OW),
    .SAMPLE_DIV(SD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_tuning  (cfg_tuning),
    .cfg_mode    (cfg_mode),
    .cfg_gate    (cfg_gate),
    .sample_out  (sample_out),
    .sample_valid(sample_valid),
    .square_out  (square_out),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Leaves the bench at the negedge where rst_n is released.
  task automatic apply_reset();
    rst_n    = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_tuning = '0;
    cfg_mode = '0;
    cfg_gate = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic write_cfg(input logic [1:0] a, input logic [AW-1:0] t,
                           input logic [1:0] m, input logic g);
    cfg_we     = 1'b1;
    cfg_addr   = a;
    cfg_tuning = t;
    cfg_mode   = m;
    cfg_gate   = g;
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Counts rising edges until sample_valid is seen at a negedge (bounded).
  task automatic wait_valid(input string tag, output int edges, output logic [OW-1:0] s);
    bit found = 1'b0;
    edges = 0;
    s     = '0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      edges++;
      if (sample_valid) begin
        found = 1'b1;
        s     = sample_out;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: no sample_valid within 64 cycles", tag);
      edges = -1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            n;
    logic [OW-1:0] s;
    logic [OW-1:0] exp_saw [5] = '{16'hF000, 16'h0000, 16'h1000, 16'hE000, 16'hF000};
    logic [OW-1:0] exp_tri [4] = '{16'h0000, 16'h1FFF, 16'hFFFF, 16'hE000};

    // Idle behaviour with no voices configured.
    rst_n = 1'b0;
    #3;
    check("reset_sample", 32'(sample_out), 32'h0);
    check("reset_valid", 32'(sample_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    apply_reset();
    check("reset_square", 32'(square_out), 32'h0);
    wait_valid("idle_first", n, s);
    check("idle_first_latency", 32'(n), 32'd12);
    check("idle_sample", 32'(s), 32'h0);
    check("idle_square", 32'(square_out), 32'h0);
    wait_valid("idle_second", n, s);
    check("idle_period", 32'(n), 32'd8);
    @(posedge clk);
    @(negedge clk);
    check("idle_valid_single", 32'(sample_valid), 32'h0);
    wait_valid("idle_third", n, s);
    check("idle_period_after", 32'(n), 32'd7);

    // Voice 0 sawtooth at a quarter of full phase per sample.
    apply_reset();
    write_cfg(2'd0, 32'h4000_0000, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      wait_valid("saw", n, s);
      check($sformatf("saw_%0d", i), 32'(s), 32'(exp_saw[i]));
    end

    // All voices square at half phase: full-scale alternating sum.
    apply_reset();
    for (int v = 0; v < NV; v++) write_cfg(2'(v), 32'h8000_0000, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("square", n, s);
      check($sformatf("square_%0d", i), 32'(s), (i % 2 == 0) ? 32'h8000 : 32'h7FFF);
      if (i == 0) check("square_msbs", 32'(square_out), 32'hF);
    end

    // Voice 1 triangle.
    apply_reset();
    write_cfg(2'd1, 32'h4000_0000, 2'b10, 1'b1);
    for (int i = 0; i < 4; i++) begin
      wait_valid("tri", n, s);
      check($sformatf("tri_%0d", i), 32'(s), 32'(exp_tri[i]));
      if (i == 1) check("tri_msbs", 32'(square_out), 32'h2);
    end

    // Gate drop, re-gate, and a config write inside the voice's own RUN slot.
    apply_reset();
    write_cfg(2'd0, 32'h4000_0000, 2'b01, 1'b1);
    wait_valid("gate_a", n, s);
    check("gate_a", 32'(s), 32'hF000);
    write_cfg(2'd0, 32'h4000_0000, 2'b01, 1'b0);
    wait_valid("gate_b", n, s);
    check("gate_off_sample", 32'(s), 32'h0);
    check("gate_off_msb", 32'(square_out), 32'h0);
    write_cfg(2'd0, 32'h4000_0000, 2'b01, 1'b1);
    wait_valid("gate_c", n, s);
    check("regate_sample", 32'(s), 32'hF000);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("slot_busy", 32'(busy), 32'h1);
    write_cfg(2'd0, 32'h0000_0000, 2'b00, 1'b1);
    wait_valid("gate_d", n, s);
    check("slot_old_cfg", 32'(s), 32'h0);
    check("slot_old_msb", 32'(square_out), 32'h1);
    wait_valid("gate_e", n, s);
    check("slot_new_cfg", 32'(s), 32'hE000);

    // Asynchronous reset in the middle of RUN.
    apply_reset();
    for (int v = 0; v < NV; v++) write_cfg(2'(v), 32'h8000_0000, 2'b00, 1'b1);
    wait_valid("mid_pre", n, s);
    check("mid_pre_sample", 32'(s), 32'h8000);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sample", 32'(sample_out), 32'h0);
    check("mid_rst_square", 32'(square_out), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_valid", 32'(sample_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_valid("mid_post", n, s);
    check("mid_post_latency", 32'(n), 32'd12);
    check("mid_post_sample", 32'(s), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
